reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameter WIDTH, default 16, data width of every register and of the bus.
REQ-002 Parameter NREGS, default 8, number of registers (2..16).
REQ-003 Parameter PC_IDX, default NREGS-1, index of the register that also acts as an incrementing counter.
REQ-004 clock  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 buswires  input  WIDTH  write data bus.
REQ-007 rin  input  NREGS  per-register load enable; bit i loads register i.
REQ-008 rout  input  NREGS  one-hot read select for dout.
REQ-009 incr_pc  input  1  increment request for register PC_IDX.
REQ-010 dout  output  WIDTH  selected register contents (combinational).
REQ-011 vld  output  NREGS  per-register "written since reset" flags.
REQ-012 err  output  1  sticky select-error flag (see Configuration).

Function
REQ-013 On a rising clock edge with rin[i]=1, register i SHALL take buswires; latency one cycle to dout.
REQ-014 Multiple rin bits set SHALL load all selected registers with the same buswires value (broadcast).
REQ-015 With rin[PC_IDX]=0 and incr_pc=1, register PC_IDX SHALL become its value +1 modulo 2^WIDTH (all-ones wraps to 0).
REQ-016 rin[PC_IDX]=1 and incr_pc=1 in the same cycle: the load SHALL win; no increment.
REQ-017 Registers with rin[i]=0 (and PC_IDX without incr_pc) SHALL hold their value.
REQ-018 vld[i] SHALL set on the first edge with rin[i]=1 and remain set until reset; incr_pc does not set vld.
REQ-019 dout SHALL equal register k when rout has exactly bit k set; 0 when rout is all zero; the bitwise OR of the selected registers when several bits are set.
REQ-020 dout SHALL reflect the pre-edge register value during the cycle a load to the same register is requested (no write-through).

Reset
REQ-021 While reset=1, every register, vld, and err SHALL be 0 immediately, independent of clock; dout therefore 0.
REQ-022 Reset asserted mid-operation SHALL discard any load or increment pending on that edge; first update after release occurs on the next rising edge with reset=0.

Configuration
REQ-023 Macro REG_BANK_ERR_EN defined: err SHALL set on any rising edge where rout has more than one bit set, and stay set until reset.
REQ-024 Macro REG_BANK_ERR_EN undefined: err SHALL be tied to 0 and no checking logic is present; all other behaviour identical.

Structure
REQ-025 Package reg_bank_pkg SHALL hold default constants (DEF_WIDTH=16, DEF_NREGS=8) and a function is_multi_hot for the rout check.
REQ-026 One sub-module reg_cell (WIDTH-parametrised register with enable and asynchronous reset) SHALL be instantiated NREGS times; the increment path lives in reg_bank.

Verification
REQ-027 Reset pulse, then rout=8'h01 -> dout=0, vld=0, err=0.
REQ-028 buswires=16'h1234, rin=8'h04 one cycle, then rout=8'h04 -> dout=16'h1234, vld=8'h04; other registers remain 0.
REQ-029 Load R7=16'hFFFE, incr_pc=1 for 3 cycles, rout=8'h80 -> dout sequence FFFF, 0000, 0001.
REQ-030 R7=16'h0010, same cycle rin=8'h80 with buswires=16'h0100 and incr_pc=1 -> R7=16'h0100, not 16'h0011.
REQ-031 rin=8'hFF, buswires=16'hA5A5 -> all registers 16'hA5A5; then rout=8'h03 -> dout=16'hA5A5 and err=1 only with REG_BANK_ERR_EN.
REQ-032 Assert reset between clock edges while rin=8'h01 -> R0 stays 0, vld=0, err clears at once.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the register bank.
package reg_bank_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 8;
    // Widest select vector the helper accepts; matches the NREGS upper bound.
    localparam int MAX_NREGS = 16;

    // True when more than one bit of the select vector is set.
    // Clearing the lowest set bit leaves a non-zero value only if another bit was set.
    function automatic logic is_multi_hot(input logic [MAX_NREGS-1:0] sel);
        return (sel & (sel - MAX_NREGS'(1))) != '0;
    endfunction

endpackage

// File: rtl/reg_cell.sv
// Single WIDTH-bit storage register with load enable and asynchronous clear.
module reg_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable, clear immediately on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/reg_bank.sv
// Register bank with broadcast load, OR-combined read port and one register
// doubling as an incrementing counter (PC_IDX).
// Optional feature: define REG_BANK_ERR_EN to enable the sticky multi-hot
// read-select error flag; otherwise err is tied low.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREGS  = DEF_NREGS,
    parameter int PC_IDX = NREGS - 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] buswires,
    input  logic [NREGS-1:0] rin,
    input  logic [NREGS-1:0] rout,
    input  logic             incr_pc,
    output logic [WIDTH-1:0] dout,
    output logic [NREGS-1:0] vld,
    output logic             err
);

    logic [NREGS-1:0][WIDTH-1:0] q;
    logic [NREGS-1:0][WIDTH-1:0] d;
    logic [NREGS-1:0]            en;

    for (genvar i = 0; i < NREGS; i++) begin : g_cell
        if (i == PC_IDX) begin : g_pc
            // A bus load takes priority over the increment.
            assign en[i] = rin[i] | incr_pc;
            assign d[i]  = rin[i] ? buswires : q[i] + WIDTH'(1);
        end else begin : g_plain
            assign en[i] = rin[i];
            assign d[i]  = buswires;
        end

        reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clock (clock),
            .reset (reset),
            .en    (en[i]),
            .d     (d[i]),
            .q     (q[i])
        );
    end

    // Read port: OR of every selected register, zero when nothing selected.
    always_comb begin
        dout = '0;
        for (int i = 0; i < NREGS; i++)
            if (rout[i]) dout = dout | q[i];
    end

    // Written-since-reset flags; only bus loads count, increments do not.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) vld <= '0;
        else       vld <= vld | rin;
    end

`ifdef REG_BANK_ERR_EN
    logic [MAX_NREGS-1:0] rout_ext;
    assign rout_ext = MAX_NREGS'(rout);

    // Sticky flag for any edge seen with more than one read select active.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                       err <= 1'b0;
        else if (is_multi_hot(rout_ext)) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboarded bench for reg_bank: stimulus pushes expected read-port values
// from a behavioural model, a monitor pops and compares once per cycle.
module tb_reg_bank;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int PC = N - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  buswires = '0;
    logic [N-1:0]  rin = '0;
    logic [N-1:0]  rout = '0;
    logic          incr_pc = 1'b0;
    logic [W-1:0]  dout;
    logic [N-1:0]  vld;
    logic          err;

    reg_bank #(.WIDTH(W), .NREGS(N), .PC_IDX(PC)) dut (
        .clock    (clock),
        .reset    (reset),
        .buswires (buswires),
        .rin      (rin),
        .rout     (rout),
        .incr_pc  (incr_pc),
        .dout     (dout),
        .vld      (vld),
        .err      (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] dout;
        logic [N-1:0] vld;
        logic         err;
        string        tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // behavioural model state
    logic [W-1:0] m_reg [N];
    logic [N-1:0] m_vld;
    logic         m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_reg[i] = '0;
        m_vld = '0;
        m_err = 1'b0;
    endtask

    // One clock of stimulus: drive, predict the pre-edge read port, then
    // advance the model by the rules for a clock edge.
    task automatic step(input string tag, input logic [N-1:0] r_in, input logic [N-1:0] r_out,
                        input logic [W-1:0] bus, input logic inc);
        exp_t e;
        logic [W-1:0] nxt [N];
        @(negedge clock);
        rin = r_in; rout = r_out; buswires = bus; incr_pc = inc;
        e.dout = '0;
        for (int i = 0; i < N; i++) if (r_out[i]) e.dout |= m_reg[i];
        e.vld = m_vld;
        e.err = m_err;
        e.tag = tag;
        exp_q.push_back(e);
        @(posedge clock);
        for (int i = 0; i < N; i++) begin
            if (r_in[i])               nxt[i] = bus;
            else if (i == PC && inc)   nxt[i] = W'((32'(m_reg[i]) + 1) % 65536);
            else                       nxt[i] = m_reg[i];
        end
        for (int i = 0; i < N; i++) m_reg[i] = nxt[i];
        m_vld = m_vld | r_in;
`ifdef REG_BANK_ERR_EN
        if ($countones(r_out) > 1) m_err = 1'b1;
`endif
    endtask

    // Monitor: the read port is valid every cycle, compare once the inputs settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".dout"}, 32'(dout), 32'(e.dout));
                chk({e.tag, ".vld"},  32'(vld),  32'(e.vld));
                chk({e.tag, ".err"},  32'(err),  32'(e.err));
            end
        end
    end

    initial begin
        logic [N-1:0] ri, ro;
        model_clear();
        rout = 8'h01;
        #3;
        chk("rst.dout", 32'(dout), 0);
        chk("rst.vld",  32'(vld),  0);
        chk("rst.err",  32'(err),  0);
        @(negedge clock);
        reset = 1'b0;

        // post-reset read
        step("r027", 8'h00, 8'h01, 16'h0000, 1'b0);
        // single load then readback
        step("r028a", 8'h04, 8'h04, 16'h1234, 1'b0);
        step("r028b", 8'h00, 8'h04, 16'h0000, 1'b0);
        step("r028c", 8'h00, 8'h02, 16'h0000, 1'b0);
        step("r028d", 8'h00, 8'h08, 16'h0000, 1'b0);
        // counter wrap
        step("r029a", 8'h80, 8'h80, 16'hFFFE, 1'b0);
        step("r029b", 8'h00, 8'h80, 16'h0000, 1'b1);
        step("r029c", 8'h00, 8'h80, 16'h0000, 1'b1);
        step("r029d", 8'h00, 8'h80, 16'h0000, 1'b1);
        step("r029e", 8'h00, 8'h80, 16'h0000, 1'b0);
        // load beats increment
        step("r030a", 8'h80, 8'h80, 16'h0010, 1'b0);
        step("r030b", 8'h80, 8'h80, 16'h0100, 1'b1);
        step("r030c", 8'h00, 8'h80, 16'h0000, 1'b0);
        // broadcast and multi-select read
        step("r031a", 8'hFF, 8'h00, 16'hA5A5, 1'b0);
        step("r031b", 8'h00, 8'h03, 16'h0000, 1'b0);
        step("r031c", 8'h00, 8'h40, 16'h0000, 1'b0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            ri = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            case ($urandom_range(0, 3))
                0:       ro = '0;
                1, 2:    ro = N'(1) << $urandom_range(0, N - 1);
                default: ro = N'($urandom);
            endcase
            step("rand", ri, ro, W'($urandom), 1'($urandom));
        end
        step("rand.end", 8'h00, 8'h01, 16'h0000, 1'b0);

        // reset asserted between edges while a load is pending
        @(negedge clock);
        rin = 8'h01; rout = 8'h01; buswires = 16'hBEEF; incr_pc = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("r032.dout", 32'(dout), 0);
        chk("r032.vld",  32'(vld),  0);
        chk("r032.err",  32'(err),  0);
        @(posedge clock);
        #1;
        chk("r032.hold.dout", 32'(dout), 0);
        chk("r032.hold.vld",  32'(vld),  0);
        model_clear();
        @(negedge clock);
        rin = '0; incr_pc = 1'b0;
        reset = 1'b0;
        step("r032a", 8'h00, 8'h01, 16'h0000, 1'b0);
        step("r032b", 8'h00, 8'h80, 16'h0000, 1'b1);
        step("r032c", 8'h00, 8'h80, 16'h0000, 1'b0);
        step("r032d", 8'h00, 8'h01, 16'h0000, 1'b0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clock);
        @(negedge clock);
        #2;
        chk("drain", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
